// File: rtl/mosbius_pkg.sv
// Shared types and defaults for the MOSbius configuration loader.
// Optional readback verification is enabled with MOSBIUS_CFG_VERIFY_EN.
package mosbius_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_DONE
    } cfg_state_t;

    localparam int DEF_CHAIN_LEN  = 100;
    localparam int DEF_CLR_CYCLES = 4;

endpackage

// File: rtl/mosbius_frame_buf.sv
// Frame register: byte-indexed writes, single-bit reads, plus whole-frame
// load/clear so the same block can serve as the readback shadow.
module mosbius_frame_buf
    import mosbius_pkg::*;
#(
    parameter int NBITS  = DEF_CHAIN_LEN,
    parameter int NBYTES = (NBITS + 7) / 8,
    parameter int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1,
    parameter int IW     = $clog2(NBITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load_en,
    input  logic [NBITS-1:0] i_load_bits,
    input  logic             i_wr_en,
    input  logic [BW-1:0]    i_wr_idx,
    input  logic [7:0]       i_wr_data,
    input  logic [IW-1:0]    i_rd_idx,
    output logic             o_rd_bit,
    output logic [NBITS-1:0] o_bits
);

    logic [NBITS-1:0] r_bits;
    logic [NBITS-1:0] w_wr_bits;

    // Bits of the last byte beyond NBITS have no storage and are dropped here.
    for (genvar b = 0; b < NBITS; b++) begin : g_bit
        assign w_wr_bits[b] = (i_wr_idx == BW'(b / 8)) ? i_wr_data[b % 8] : r_bits[b];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bits <= '0;
        end else if (i_clr) begin
            r_bits <= '0;
        end else if (i_load_en) begin
            r_bits <= i_load_bits;
        end else if (i_wr_en) begin
            r_bits <= w_wr_bits;
        end
    end

    assign o_rd_bit = r_bits[i_rd_idx];
    assign o_bits   = r_bits;

endmodule

// File: rtl/mosbius_cfg_loader.sv
// MOSbius switch-chain configuration sequencer: byte frame in, serial shift,
// latch strobe, chain clear. Readback check is built with MOSBIUS_CFG_VERIFY_EN.
module mosbius_cfg_loader
    import mosbius_pkg::*;
#(
    parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
    parameter int CLR_CYCLES = DEF_CLR_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cfg_byte,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic       cmd_clear,
    output logic       busy,
    output logic       done,
    output logic       sr_dat,
    output logic       sr_en,
    output logic       sr_latch,
    output logic       sr_rst_n,
    input  logic       sr_dat_out,
    output logic       vfy_err
);

    localparam int NBYTES  = (CHAIN_LEN + 7) / 8;
    localparam int BW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int IW      = $clog2(CHAIN_LEN);
    localparam int CW      = $clog2(CHAIN_LEN + 1);
    localparam int KW      = $clog2(CLR_CYCLES + 1);
    localparam int TOP_POS = (CHAIN_LEN - 1) % 8;

    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
    localparam logic [CW-1:0] BIT_TC    = CW'(CHAIN_LEN);
    localparam logic [KW-1:0] CLR_TC    = KW'(CLR_CYCLES - 1);

    cfg_state_t      r_state;
    logic            r_cfg_ready;
    logic            r_busy;
    logic            r_done;
    logic            r_sr_dat;
    logic            r_sr_en;
    logic            r_sr_latch;
    logic            r_sr_rst_n;
    logic [BW-1:0]   r_byte_cnt;
    logic [CW-1:0]   r_bit_cnt;
    logic [KW-1:0]   r_clr_cnt;

    logic                 w_accept;
    logic                 w_frame_bit;
    logic [IW-1:0]        w_rd_idx;
    logic [CHAIN_LEN-1:0] w_frame_bits;

    // Handshake valid/ready: a byte transfers on a rising edge where both
    // cfg_valid and cfg_ready are high. The only combinational term is the
    // clear override in IDLE, so a clear request never also consumes a byte.
    assign cfg_ready = r_cfg_ready & ~((r_state == ST_IDLE) & cmd_clear);
    assign w_accept  = cfg_valid & cfg_ready;

    // r_bit_cnt counts bits already presented; it reads the next bit to send.
    assign w_rd_idx = (r_bit_cnt >= BIT_TC) ? '0 : IW'(BIT_TC - CW'(1) - r_bit_cnt);

    mosbius_frame_buf #(
        .NBITS (CHAIN_LEN)
    ) u_frame (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (1'b0),
        .i_load_en   (1'b0),
        .i_load_bits ('0),
        .i_wr_en     (w_accept),
        .i_wr_idx    (r_byte_cnt),
        .i_wr_data   (cfg_byte),
        .i_rd_idx    (w_rd_idx),
        .o_rd_bit    (w_frame_bit),
        .o_bits      (w_frame_bits)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sr_dat    <= 1'b0;
            r_sr_en     <= 1'b0;
            r_sr_latch  <= 1'b0;
            r_sr_rst_n  <= 1'b0;
            r_byte_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_clr_cnt   <= '0;
        end else begin
            r_done     <= 1'b0;
            r_sr_latch <= 1'b0;
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    r_sr_rst_n <= 1'b1;
                    if (r_state == ST_IDLE && cmd_clear) begin
                        r_state     <= ST_CLEAR;
                        r_cfg_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_sr_rst_n  <= 1'b0;
                        r_clr_cnt   <= '0;
                    end else if (w_accept) begin
                        r_busy <= 1'b1;
                        if (r_byte_cnt == LAST_BYTE) begin
                            // The top chain bit lives in the byte arriving now,
                            // so the first serial bit bypasses the buffer.
                            r_state     <= ST_SHIFT;
                            r_cfg_ready <= 1'b0;
                            r_byte_cnt  <= '0;
                            r_sr_en     <= 1'b1;
                            r_sr_dat    <= cfg_byte[TOP_POS];
                            r_bit_cnt   <= CW'(1);
                        end else begin
                            r_state    <= ST_LOAD;
                            r_byte_cnt <= r_byte_cnt + BW'(1);
                        end
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == CLR_TC) begin
                        r_state     <= ST_IDLE;
                        r_cfg_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_sr_rst_n  <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + KW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (r_bit_cnt == BIT_TC) begin
                        r_state    <= ST_LATCH;
                        r_sr_en    <= 1'b0;
                        r_sr_dat   <= 1'b0;
                        r_sr_latch <= 1'b1;
                    end else begin
                        r_sr_dat  <= w_frame_bit;
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                    end
                end
                ST_LATCH: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_cfg_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_bit_cnt   <= '0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cfg_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_sr_en     <= 1'b0;
                    r_sr_dat    <= 1'b0;
                end
            endcase
        end
    end

`ifdef MOSBIUS_CFG_VERIFY_EN
    logic                 r_vfy_err;
    logic                 w_shadow_bit;
    logic [IW-1:0]        w_vfy_idx;
    logic [CHAIN_LEN-1:0] w_unused_shadow_bits;

    // In shift cycle i the chain tail shows old bit CHAIN_LEN-1-i; r_bit_cnt is i+1.
    assign w_vfy_idx = (r_bit_cnt == '0) ? '0 : IW'(BIT_TC - r_bit_cnt);

    mosbius_frame_buf #(
        .NBITS (CHAIN_LEN)
    ) u_shadow (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (r_state == ST_CLEAR),
        .i_load_en   (r_state == ST_LATCH),
        .i_load_bits (w_frame_bits),
        .i_wr_en     (1'b0),
        .i_wr_idx    ('0),
        .i_wr_data   ('0),
        .i_rd_idx    (w_vfy_idx),
        .o_rd_bit    (w_shadow_bit),
        .o_bits      (w_unused_shadow_bits)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vfy_err <= 1'b0;
        end else if (r_state == ST_IDLE && w_accept) begin
            r_vfy_err <= 1'b0;
        end else if (r_state == ST_SHIFT && sr_dat_out != w_shadow_bit) begin
            r_vfy_err <= 1'b1;
        end
    end

    assign vfy_err = r_vfy_err;
`else
    logic w_unused_vfy;
    assign w_unused_vfy = ^{sr_dat_out, w_frame_bits};
    assign vfy_err      = 1'b0;
`endif

    assign busy     = r_busy;
    assign done     = r_done;
    assign sr_dat   = r_sr_dat;
    assign sr_en    = r_sr_en;
    assign sr_latch = r_sr_latch;
    assign sr_rst_n = r_sr_rst_n;

endmodule

// File: tb/tb_mosbius_cfg_loader.sv
// Directed bench for mosbius_cfg_loader with a chain model and latch scoreboard.
// Covers MOSBIUS_CFG_VERIFY_EN readback when that macro is defined.
module tb_mosbius_cfg_loader;

    localparam int CL = 100;
`ifdef MOSBIUS_CFG_VERIFY_EN
    localparam logic VFY = 1'b1;
`else
    localparam logic VFY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cfg_byte = '0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic       cmd_clear = 1'b0;
    logic       busy, done, sr_dat, sr_en, sr_latch, sr_rst_n, sr_dat_out, vfy_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [CL-1:0] exp_q[$];
    logic [CL-1:0] chain;
    int            sh_idx;
    logic          flip_en = 1'b0;
    logic          vfy_after_b0;

    mosbius_cfg_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_byte   (cfg_byte),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cmd_clear  (cmd_clear),
        .busy       (busy),
        .done       (done),
        .sr_dat     (sr_dat),
        .sr_en      (sr_en),
        .sr_latch   (sr_latch),
        .sr_rst_n   (sr_rst_n),
        .sr_dat_out (sr_dat_out),
        .vfy_err    (vfy_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- chain model ----------------
    always_ff @(posedge clk or negedge sr_rst_n) begin
        if (!sr_rst_n) chain <= '0;
        else if (sr_en) chain <= {chain[CL-2:0], sr_dat};
    end

    always_ff @(posedge clk) begin
        if (sr_en) sh_idx <= sh_idx + 1;
        else       sh_idx <= 0;
    end

    // Corrupt the readback of old bit 7 (shift cycle 92) when requested.
    assign sr_dat_out = chain[CL-1] ^ (flip_en && sh_idx == CL - 1 - 7);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- scoreboard monitor ----------------
    int   run = 0;
    logic done_pending = 1'b0;
    always @(negedge clk) begin
        logic [CL-1:0] e;
        if (rst_n) begin
            if (done_pending) begin
                chk("done_pulse", {127'b0, done}, 128'd1);
                done_pending = 1'b0;
            end
            if (!sr_en && sr_dat) chk("dat_idle_zero", {127'b0, sr_dat}, 128'd0);
            if (sr_en) begin
                run++;
            end else begin
                if (sr_latch) begin
                    chk("en_cycles", 128'(run), 128'(CL));
                    if (exp_q.size() == 0) begin
                        chk("unexpected_latch", 128'd1, 128'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("chain_frame", 128'(chain), 128'(e));
                    end
                    done_pending = 1'b1;
                end
                run = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic [103:0] f, input logic [CL-1:0] e, input logic push);
        int t;
        if (push) exp_q.push_back(e);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            cfg_byte  = f[8*k +: 8];
            cfg_valid = 1'b1;
            t = 0;
            while (!cfg_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) chk("hs_timeout", {127'b0, cfg_ready}, 128'd1);
            @(posedge clk);
            #1;
            if (k == 0) vfy_after_b0 = vfy_err;
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("ready_drop", {127'b0, cfg_ready}, 128'd0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("idle_reached", {127'b0, busy}, 128'd0);
        @(negedge clk);
    endtask

    localparam logic [103:0] F1 = 104'h00_0000_0000_0000_0000_0000_0001;
    localparam logic [CL-1:0] E1 = 100'h0_0000_0000_0000_0000_0000_0001;
    localparam logic [103:0] F2 = 104'hFF_0123_4567_89AB_CDEF_0011_2233;
    localparam logic [CL-1:0] E2 = 100'hF_0123_4567_89AB_CDEF_0011_2233;
    localparam logic [103:0] F3 = 104'hF8_5555_5555_5555_5555_5555_5555;
    localparam logic [CL-1:0] E3 = 100'h8_5555_5555_5555_5555_5555_5555;
    localparam logic [103:0] FA = 104'h0A_CAFE_BABE_DEAD_BEEF_1234_5678;
    localparam logic [CL-1:0] EA = 100'hA_CAFE_BABE_DEAD_BEEF_1234_5678;
    localparam logic [103:0] FB = 104'h35_0F0F_F0F0_1357_9BDF_2468_ACE0;
    localparam logic [CL-1:0] EB = 100'h5_0F0F_F0F0_1357_9BDF_2468_ACE0;

    // ---------------- stimulus ----------------
    initial begin
        int lo, bz;
        #1;
        chk("rst_sr_rst_n_low", {127'b0, sr_rst_n}, 128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_sr_rst_n_still_low", {127'b0, sr_rst_n}, 128'd0);
        @(negedge clk);
        chk("rel_sr_rst_n_high", {127'b0, sr_rst_n}, 128'd1);
        chk("rst_outputs", {122'b0, cfg_ready, busy, done, sr_en, sr_latch, vfy_err}, 128'b100000);

        // single set bit: must end up at the chain head only
        send_frame(F1, E1, 1'b1);
        wait_idle();
        chk("ready_back", {127'b0, cfg_ready}, 128'd1);

        // clear in IDLE
        @(negedge clk);
        cmd_clear = 1'b1;
        @(negedge clk);
        cmd_clear = 1'b0;
        lo = 0;
        bz = 0;
        for (int i = 0; i < 20; i++) begin
            if (!sr_rst_n) lo++;
            if (busy) bz++;
            @(negedge clk);
        end
        chk("clear_len", 128'(lo), 128'd4);
        chk("clear_busy_len", 128'(bz), 128'd4);
        chk("chain_cleared", 128'(chain), 128'd0);

        // clear during SHIFT is dropped
        send_frame(F2, E2, 1'b1);
        repeat (10) @(negedge clk);
        cmd_clear = 1'b1;
        @(negedge clk);
        cmd_clear = 1'b0;
        chk("clr_in_shift", {126'b0, sr_rst_n, sr_en}, 128'b11);
        wait_idle();

        // clear and valid together: clear wins, byte not taken
        @(negedge clk);
        cmd_clear = 1'b1;
        cfg_valid = 1'b1;
        cfg_byte  = 8'hAA;
        #1;
        chk("clr_wins_ready", {127'b0, cfg_ready}, 128'd0);
        @(negedge clk);
        cmd_clear = 1'b0;
        cfg_valid = 1'b0;
        chk("clr_wins_state", {126'b0, busy, sr_rst_n}, 128'b10);
        wait_idle();
        send_frame(F3, E3, 1'b1);
        wait_idle();

        // reset during shift cycle 50
        send_frame(F2, E2, 1'b0);
        repeat (50) @(negedge clk);
        chk("shift_mid_en", {127'b0, sr_en}, 128'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {125'b0, sr_en, sr_rst_n, busy}, 128'b000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(F3, E3, 1'b1);
        wait_idle();

        // readback verification
        send_frame(FA, EA, 1'b1);
        wait_idle();
        chk("vfy_clean", {127'b0, vfy_err}, 128'd0);
        flip_en = 1'b1;
        send_frame(FB, EB, 1'b1);
        wait_idle();
        flip_en = 1'b0;
        chk("vfy_set", {127'b0, vfy_err}, {127'b0, VFY});
        send_frame(F1, E1, 1'b1);
        chk("vfy_clr_b0", {127'b0, vfy_after_b0}, 128'd0);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("exp_q_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
